// File: rtl/sub_serial_pkg.sv
// Shared encodings for the serial arithmetic FSMs (subtractor / adder).
package sub_serial_pkg;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_SUB  = 3'd1,
    ST_DONE = 3'd2
  } state_e;
endpackage

// File: rtl/sub_serial_if.sv
// Start/result bus between a controller and the bit-serial subtractor.
interface sub_serial_if #(parameter int WIDTH = 8);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             borrow;
  logic             busy;
  logic             done;

  modport master (output en, a, b, input out, borrow, busy, done);
  modport slave  (input en, a, b, output out, borrow, busy, done);
endinterface

// File: rtl/serial_full_sub.sv
// One-bit full subtractor cell: x - y - bin -> d, bout.
module serial_full_sub (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);
endmodule

// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor: out = a - b, LSB first, one bit per clk,
// result shifted in from the MSB end so it lands aligned after WIDTH steps.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  sub_serial_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [STATE_W-1:0] S_IDLE = ST_IDLE;
  localparam logic [STATE_W-1:0] S_SUB  = ST_SUB;
  localparam logic [STATE_W-1:0] S_DONE = ST_DONE;

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, out_q, out_d;
  logic               borrow_q, borrow_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               diff_bit, bout;

  serial_full_sub u_cell (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (borrow_q),
    .d    (diff_bit),
    .bout (bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: if (bus.en) begin
        a_d      = bus.a;
        b_d      = bus.b;
        borrow_d = 1'b0;
        cnt_d    = '0;
        out_d    = '0;
        state_d  = S_SUB;
      end
      S_SUB: begin
        out_d    = {diff_bit, out_q[WIDTH-1:1]};
        borrow_d = bout;
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = S_DONE;
      end
      // Holding en in DONE parks here so one start yields one computation.
      S_DONE: if (!bus.en) state_d = S_IDLE;
      default: begin
        state_d  = S_IDLE;
        a_d      = '0;
        b_d      = '0;
        out_d    = '0;
        borrow_d = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.borrow = borrow_q;
  assign bus.busy   = (state_q == S_SUB);
  assign bus.done   = (state_q == S_DONE);
endmodule
